// File: rtl/dram_addr_mux_seq.sv
// DRAM address-mux sequencer: one 14-tick memory cycle (video half, then CPU
// half) driving mux selects/enables, RASn/CASn/WEn and data-latch strobes.
// The last cycle of each video line is stretched by STRETCH precharge ticks.
module dram_addr_mux_seq #(
  parameter int LINE_CYCLES = 65,
  parameter int STRETCH     = 2
) (
  input  logic CLK14M,
  input  logic RESET,
  input  logic RUN,
  input  logic CPU_WE,
  output logic S0_14,
  output logic S1_2,
  output logic Ean_n,
  output logic Ebn_n,
  output logic RASn,
  output logic CASn,
  output logic WEn,
  output logic PHI0,
  output logic VID_LATCH,
  output logic CPU_LATCH,
  output logic LONG_CYC
);

  localparam int CW = (LINE_CYCLES > 1) ? $clog2(LINE_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST     = CW'(LINE_CYCLES - 1);
  localparam logic [3:0]    T_NORM_END = 4'd13;
  localparam logic [3:0]    T_LONG_END = 4'(13 + STRETCH);

  // ST_RESET is the period right after a reset edge: reset outputs, then T0.
  typedef enum logic [1:0] {ST_RESET, ST_ACTIVE, ST_PARKED} state_t;

  state_t        state, state_nxt;
  logic [3:0]    t_q, t_nxt;
  logic [CW-1:0] c_q, c_nxt;
  logic          we_q, we_nxt;
  logic [3:0]    t_end;

  logic [3:0] t_eff, h;
  logic d_s0, d_s1, d_en, d_ras, d_cas, d_we, d_phi, d_vid, d_cpu, d_long;

  // State, counters and registered outputs.
  always_ff @(posedge CLK14M) begin
    if (RESET) begin
      state     <= ST_RESET;
      t_q       <= '0;
      c_q       <= '0;
      we_q      <= 1'b0;
      S1_2      <= 1'b0;
      S0_14     <= 1'b0;
      Ean_n     <= 1'b1;
      Ebn_n     <= 1'b1;
      RASn      <= 1'b1;
      CASn      <= 1'b1;
      WEn       <= 1'b1;
      PHI0      <= 1'b0;
      VID_LATCH <= 1'b0;
      CPU_LATCH <= 1'b0;
      LONG_CYC  <= 1'b0;
    end else begin
      state     <= state_nxt;
      t_q       <= t_nxt;
      c_q       <= c_nxt;
      we_q      <= we_nxt;
      S1_2      <= d_s1;
      S0_14     <= d_s0;
      Ean_n     <= d_en;
      Ebn_n     <= d_en;
      RASn      <= d_ras;
      CASn      <= d_cas;
      WEn       <= d_we;
      PHI0      <= d_phi;
      VID_LATCH <= d_vid;
      CPU_LATCH <= d_cpu;
      LONG_CYC  <= d_long;
    end
  end

  // Next-state: tick/cycle advance, RUN sampled at the cycle boundary,
  // CPU_WE sampled on the edge entering T7.
  always_comb begin
    state_nxt = state;
    t_nxt     = t_q;
    c_nxt     = c_q;
    we_nxt    = we_q;
    t_end     = (c_q == C_LAST) ? T_LONG_END : T_NORM_END;
    case (state)
      ST_RESET: begin
        state_nxt = ST_ACTIVE;
        t_nxt     = '0;
      end
      ST_PARKED: begin
        if (RUN) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (t_q == t_end) begin
          // The finished cycle still advances C; parking then freezes it.
          t_nxt = '0;
          c_nxt = (c_q == C_LAST) ? '0 : c_q + CW'(1);
          if (!RUN) state_nxt = ST_PARKED;
        end else begin
          t_nxt = t_q + 4'd1;
          if (t_q == 4'd6) we_nxt = CPU_WE;
        end
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  // Output decode from the next state so each register holds its value in
  // the same period as the matching tick; stretch ticks repeat T13.
  always_comb begin
    t_eff  = (t_nxt > 4'd13) ? 4'd13 : t_nxt;
    h      = (t_eff >= 4'd7) ? t_eff - 4'd7 : t_eff;
    d_s1   = 1'b0;
    d_s0   = 1'b0;
    d_en   = 1'b1;
    d_ras  = 1'b1;
    d_cas  = 1'b1;
    d_we   = 1'b1;
    d_phi  = 1'b0;
    d_vid  = 1'b0;
    d_cpu  = 1'b0;
    d_long = 1'b0;
    if (state_nxt == ST_ACTIVE) begin
      d_phi  = (t_eff >= 4'd7);
      d_s1   = d_phi;
      d_s0   = (h >= 4'd2);
      d_en   = 1'b0;
      d_ras  = !((h >= 4'd1) && (h <= 4'd5));
      d_cas  = !((h >= 4'd3) && (h <= 4'd5));
      d_we   = !(d_phi && we_nxt && (h >= 4'd3) && (h <= 4'd5));
      d_vid  = (t_nxt == 4'd5);
      d_cpu  = (t_nxt == 4'd12);
      d_long = (c_nxt == C_LAST);
    end
  end

endmodule

// File: tb/tb_dram_addr_mux_seq.sv
// Directed bench for dram_addr_mux_seq: table-driven first cycle, then
// write, line-stretch, park/resume and mid-cycle reset sequences.
module tb_dram_addr_mux_seq;

  logic CLK14M = 1'b0;
  logic RESET, RUN, CPU_WE;
  logic S0_14, S1_2, Ean_n, Ebn_n, RASn, CASn, WEn, PHI0;
  logic VID_LATCH, CPU_LATCH, LONG_CYC;

  dram_addr_mux_seq #(.LINE_CYCLES(65), .STRETCH(2)) dut (
    .CLK14M(CLK14M), .RESET(RESET), .RUN(RUN), .CPU_WE(CPU_WE),
    .S0_14(S0_14), .S1_2(S1_2), .Ean_n(Ean_n), .Ebn_n(Ebn_n),
    .RASn(RASn), .CASn(CASn), .WEn(WEn), .PHI0(PHI0),
    .VID_LATCH(VID_LATCH), .CPU_LATCH(CPU_LATCH), .LONG_CYC(LONG_CYC)
  );

  always #5 CLK14M = ~CLK14M;

  // {S1_2,S0_14,Ean_n,Ebn_n,RASn,CASn,WEn,PHI0,VID_LATCH,CPU_LATCH,LONG_CYC}
  logic [10:0] outs;
  assign outs = {S1_2, S0_14, Ean_n, Ebn_n, RASn, CASn, WEn, PHI0,
                 VID_LATCH, CPU_LATCH, LONG_CYC};

  localparam logic [10:0] RST_OUT = 11'b00_11_111_0_0_0_0;

  typedef struct {
    int          t;
    logic [10:0] exp;
  } vec_t;

  vec_t vec [14];

  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;
  logic prev_cas = 1'b1;
  logic prev_s0 = 1'b0;
  int   long_cnt = 0;
  int   last_long_len = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance one clock, sample 1 time unit later, run per-tick invariants.
  task automatic step();
    @(posedge CLK14M);
    #1;
    if (mon_en) begin
      if (CASn === 1'b0) chk("cas_implies_ras", {31'd0, RASn}, 32'd0);
      if (prev_cas === 1'b1 && CASn === 1'b0)
        chk("s0_stable_at_cas_fall", {31'd0, S0_14}, {31'd0, prev_s0});
    end
    prev_cas = CASn;
    prev_s0  = S0_14;
    if (LONG_CYC === 1'b1) long_cnt++;
    else if (long_cnt != 0) begin
      last_long_len = long_cnt;
      long_cnt = 0;
    end
  endtask

  // Expected outputs at tick t of an active cycle; ticks past 13 repeat T13.
  function automatic logic [10:0] ref_out(input int t, input bit we, input bit lng);
    int   tt, h;
    logic phi, s0, ras, cas, wen, vid, cpu;
    tt  = (t > 13) ? 13 : t;
    phi = (tt >= 7);
    h   = phi ? tt - 7 : tt;
    s0  = (h >= 2);
    ras = !(h >= 1 && h <= 5);
    cas = !(h >= 3 && h <= 5);
    wen = !(phi && we && h >= 3 && h <= 5);
    vid = (t == 5);
    cpu = (t == 12);
    return {phi, s0, 2'b00, ras, cas, wen, phi, vid, cpu, lng};
  endfunction

  task automatic chk_tick(input int t, input bit we, input bit lng);
    chk($sformatf("tick%0d_we%0d_long%0d", t, we, lng), {21'd0, outs},
        {21'd0, ref_out(t, we, lng)});
  endtask

  task automatic run_cycle(input int ticks, input bit we, input bit lng);
    for (int t = 0; t < ticks; t++) begin
      step();
      chk_tick(t, we, lng);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{0,  11'b00_00_111_0_0_0_0};
    vec[1]  = '{1,  11'b00_00_011_0_0_0_0};
    vec[2]  = '{2,  11'b01_00_011_0_0_0_0};
    vec[3]  = '{3,  11'b01_00_001_0_0_0_0};
    vec[4]  = '{4,  11'b01_00_001_0_0_0_0};
    vec[5]  = '{5,  11'b01_00_001_0_1_0_0};
    vec[6]  = '{6,  11'b01_00_111_0_0_0_0};
    vec[7]  = '{7,  11'b10_00_111_1_0_0_0};
    vec[8]  = '{8,  11'b10_00_011_1_0_0_0};
    vec[9]  = '{9,  11'b11_00_011_1_0_0_0};
    vec[10] = '{10, 11'b11_00_001_1_0_0_0};
    vec[11] = '{11, 11'b11_00_001_1_0_0_0};
    vec[12] = '{12, 11'b11_00_001_1_0_1_0};
    vec[13] = '{13, 11'b11_00_111_1_0_0_0};

    RESET = 1'b1; RUN = 1'b0; CPU_WE = 1'b0;
    repeat (2) step();
    chk("reset_outputs", {21'd0, outs}, {21'd0, RST_OUT});
    mon_en = 1;

    // Line 1, cycle 0: table-driven trace.
    RESET = 1'b0; RUN = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      chk($sformatf("table_t%0d", vec[i].t), {21'd0, outs}, {21'd0, vec[i].exp});
    end

    // Cycle 1: CPU_WE held across the T7 sample edge, dropped for T8.
    CPU_WE = 1'b1;
    for (int t = 0; t < 14; t++) begin
      step();
      chk_tick(t, 1'b1, 1'b0);
      if (t == 7) CPU_WE = 1'b0;
    end

    // Cycle 2: CPU_WE pulses away from the sample edge must be ignored.
    for (int t = 0; t < 14; t++) begin
      CPU_WE = (t >= 1 && t <= 5) || (t >= 8 && t <= 12);
      step();
      chk_tick(t, 1'b0, 1'b0);
    end
    CPU_WE = 1'b0;

    // Cycles 3..63 normal, cycle 64 stretched.
    for (int c = 3; c < 64; c++) run_cycle(14, 1'b0, 1'b0);
    run_cycle(16, 1'b0, 1'b1);

    // Line 2: cycle 0 back to normal.
    run_cycle(14, 1'b0, 1'b0);
    chk("long_cycle_len", last_long_len, 32'd16);
    for (int c = 1; c < 63; c++) run_cycle(14, 1'b0, 1'b0);

    // Cycle 63: RUN drops at T4, cycle completes, then parks.
    for (int t = 0; t < 14; t++) begin
      step();
      chk_tick(t, 1'b0, 1'b0);
      if (t == 4) RUN = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("parked_%0d", k), {21'd0, outs}, {21'd0, RST_OUT});
    end
    // Resume: C was held, so this must be the stretched cycle 64.
    RUN = 1'b1;
    run_cycle(16, 1'b0, 1'b1);
    run_cycle(14, 1'b0, 1'b0);
    chk("long_cycle_len_resume", last_long_len, 32'd16);

    // Line 3, cycle 1: write latched, reset during T11 aborts the cycle.
    CPU_WE = 1'b1;
    for (int t = 0; t < 12; t++) begin
      step();
      chk_tick(t, 1'b1, 1'b0);
      if (t == 7) CPU_WE = 1'b0;
    end
    RESET = 1'b1;
    step();
    chk("reset_abort", {21'd0, outs}, {21'd0, RST_OUT});
    RESET = 1'b0;

    // After reset C restarts at 0: 64 normal cycles then the stretched one.
    for (int c = 0; c < 64; c++) run_cycle(14, 1'b0, 1'b0);
    run_cycle(16, 1'b0, 1'b1);
    run_cycle(14, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
